// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Configuration macro consumed by this slice: FETCH_PERF_CNT_EN (see instr_fetch_unit).
package fetch_pkg;

    localparam int FETCH_DEPTH = 2;
    localparam int FETCH_PTR_W = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;
    localparam int FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);
    localparam int FETCH_PC_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]           inst;
        logic [FETCH_PC_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [FETCH_PTR_W-1:0] ptr_inc(input logic [FETCH_PTR_W-1:0] ptr);
        if (ptr == FETCH_PTR_W'(FETCH_DEPTH - 1)) begin
            return '0;
        end
        return ptr + FETCH_PTR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO buffering fetched instructions ahead of decode.
// Flush wins over push and pop issued in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [DATA_W-1:0]      push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [DATA_W-1:0]      head_o,
    output logic [FETCH_CNT_W-1:0] count_o
);

    logic [DATA_W-1:0]      mem_q [FETCH_DEPTH];
    logic [FETCH_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FETCH_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FETCH_CNT_W-1:0] count_q, count_d;
    logic                   do_push;
    logic                   do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + FETCH_CNT_W'(1);
                2'b01:   count_d = count_q - FETCH_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    generate
        for (genvar gi = 0; gi < FETCH_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (do_push && (wr_ptr_q == FETCH_PTR_W'(gi))) begin
                    mem_q[gi] <= push_data_i;
                end
            end
        end
    endgenerate

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: word PC, single outstanding imem read, 2-entry queue to decode.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_flushed counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed,
`endif
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int ENTRY_W = 32 + ADDR_W;

    fetch_state_e           state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [FETCH_CNT_W-1:0] q_count;
    logic [ENTRY_W-1:0]     q_head;
    logic                   q_push;
    logic                   q_pop;

    // Requests are held off during a redirect so the new PC is used next cycle.
    assign imem_req   = (state_q == IDLE) && (q_count < FETCH_CNT_W'(FETCH_DEPTH))
                        && !redirect_valid && !rst;
    assign imem_addr  = pc_q;
    assign inst_valid = (q_count != '0) && !redirect_valid;
    assign q_pop      = inst_valid && inst_ready;
    assign q_push     = (state_q == WAIT) && imem_rvalid && !redirect_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (imem_req) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = WAIT;
                end
            end
            WAIT, DROP: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // The in-flight word belongs to pc-1 since pc advanced when it was issued.
    fetch_queue #(
        .DATA_W(ENTRY_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_i     (q_push),
        .push_data_i({imem_rdata, pc_q - ADDR_W'(1)}),
        .pop_i      (q_pop),
        .flush_i    (redirect_valid),
        .head_o     (q_head),
        .count_o    (q_count)
    );

    assign inst    = q_head[ENTRY_W-1 -: 32];
    assign inst_pc = q_head[ADDR_W-1:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;
    logic        flush_hits;

    // Only a live (WAIT) request counts as discarded work; a DROP request is already stale.
    assign flush_hits = redirect_valid && ((q_count != '0) || (state_q == WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (q_pop) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (flush_hits) begin
                perf_flushed_q <= perf_flushed_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-configurable memory model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed, w_perf_fetched, w_perf_flushed;
`endif

    int checks   = 0;
    int failures = 0;
    int lat      = 1;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'd0), .ADDR_W(32)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched  (perf_fetched),
        .perf_flushed  (perf_flushed),
`endif
        .inst_pc       (inst_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .ADDR_W(32)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_rvalid   (w_rvalid),
        .imem_rdata    (32'h5A5A_0000),
        .redirect_valid(1'b0),
        .redirect_pc   (32'd0),
        .inst_valid    (w_inst_valid),
        .inst_ready    (1'b1),
        .inst          (w_inst),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched  (w_perf_fetched),
        .perf_flushed  (w_perf_flushed),
`endif
        .inst_pc       (w_inst_pc)
    );

    // Memory model: answers addr+0x100 after 'lat' cycles, reset with the DUT.
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_addr;
    always @(posedge clk) begin
        if (rst) begin
            m_pend      <= 1'b0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'd0;
            m_cnt       <= 0;
            m_addr      <= 32'd0;
        end else begin
            imem_rvalid <= 1'b0;
            if (m_pend) begin
                if (m_cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= m_addr + 32'h100;
                    m_pend      <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (imem_req) begin
                if (lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= imem_addr + 32'h100;
                end else begin
                    m_pend <= 1'b1;
                    m_cnt  <= lat - 1;
                    m_addr <= imem_addr;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) w_rvalid <= 1'b0;
        else     w_rvalid <= w_req;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        lat            = 1;
        cyc();
        cyc();
        chk("rst_req",   64'(imem_req),   64'd0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst",  64'(inst),       64'd0);
        chk("rst_pc",    64'(inst_pc),    64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_f", 64'(perf_fetched), 64'd0);
        chk("rst_perf_x", 64'(perf_flushed), 64'd0);
`endif
        // Streaming with 1-cycle memory: one instruction every two cycles.
        rst = 1'b0;
        #1;
        $display("T1 stream: first request");
        chk("t1_req0",   64'(imem_req),  64'd1);
        chk("t1_addr0",  64'(imem_addr), 64'd0);
        chk("wrap_req0", 64'(w_req),     64'd1);
        chk("wrap_addr0",64'(w_addr),    64'hFFFF_FFFF);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t1_odd_valid", 64'(inst_valid), 64'd0);
            chk("t1_odd_req",   64'(imem_req),   64'd0);
            cyc();
            $display("T1 stream: k=%0d inst=%h inst_pc=%h addr=%h", k, inst, inst_pc, imem_addr);
            chk("t1_valid", 64'(inst_valid), 64'd1);
            chk("t1_inst",  64'(inst),       64'(32'h100 + k));
            chk("t1_pc",    64'(inst_pc),    64'(k));
            chk("t1_req",   64'(imem_req),   64'd1);
            chk("t1_addr",  64'(imem_addr),  64'(k + 1));
            if (k == 0) begin
                chk("wrap_addr1",  64'(w_addr),    64'd0);
                chk("wrap_instpc", 64'(w_inst_pc), 64'hFFFF_FFFF);
                chk("wrap_inst",   64'(w_inst),    64'h5A5A_0000);
            end
        end

        // Backpressure: two buffered, fetching stalls, then drains in order.
        inst_ready = 1'b0;
        do_reset();
        cyc(); cyc(); cyc(); cyc();
        $display("T2 stall: valid=%b inst_pc=%h req=%b", inst_valid, inst_pc, imem_req);
        chk("t2_c4_valid", 64'(inst_valid), 64'd1);
        chk("t2_c4_pc",    64'(inst_pc),    64'd0);
        chk("t2_c4_req",   64'(imem_req),   64'd0);
        cyc();
        chk("t2_c5_req",   64'(imem_req),   64'd0);
        cyc();
        inst_ready = 1'b1;
        #1;
        chk("t2_c6_pc",    64'(inst_pc),    64'd0);
        chk("t2_c6_req",   64'(imem_req),   64'd0);
        cyc();
        $display("T2 drain: inst=%h inst_pc=%h req=%b addr=%h", inst, inst_pc, imem_req, imem_addr);
        chk("t2_c7_valid", 64'(inst_valid), 64'd1);
        chk("t2_c7_pc",    64'(inst_pc),    64'd1);
        chk("t2_c7_inst",  64'(inst),       64'h101);
        chk("t2_c7_req",   64'(imem_req),   64'd1);
        chk("t2_c7_addr",  64'(imem_addr),  64'd2);
        cyc();
        chk("t2_c8_valid", 64'(inst_valid), 64'd0);
        cyc();
        chk("t2_c9_pc",    64'(inst_pc),    64'd2);

        // Redirect while a 3-cycle read is outstanding: stale word dropped.
        lat = 3;
        do_reset();
        chk("t3_req0", 64'(imem_req), 64'd1);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        chk("t3_c1_req",   64'(imem_req),   64'd0);
        chk("t3_c1_valid", 64'(inst_valid), 64'd0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("t3_c2_state", 64'(u_dut.state_q), 64'(DROP));
        chk("t3_c2_req",   64'(imem_req),      64'd0);
        cyc();
        $display("T3 stale response: rvalid=%b state=%0d", imem_rvalid, u_dut.state_q);
        chk("t3_c3_rvalid", 64'(imem_rvalid),   64'd1);
        chk("t3_c3_state",  64'(u_dut.state_q), 64'(DROP));
        chk("t3_c3_req",    64'(imem_req),      64'd0);
        cyc();
        chk("t3_c4_req",   64'(imem_req),   64'd1);
        chk("t3_c4_addr",  64'(imem_addr),  64'h40);
        chk("t3_c4_valid", 64'(inst_valid), 64'd0);
        cyc(); cyc(); cyc(); cyc();
        $display("T3 delivered: inst=%h inst_pc=%h", inst, inst_pc);
        chk("t3_c8_valid", 64'(inst_valid), 64'd1);
        chk("t3_c8_pc",    64'(inst_pc),    64'h40);
        chk("t3_c8_inst",  64'(inst),       64'h140);
        chk("t3_c8_addr",  64'(imem_addr),  64'h41);

        // Redirect coinciding with a response while the queue holds one entry.
        lat        = 1;
        inst_ready = 1'b0;
        do_reset();
        cyc(); cyc(); cyc();
        chk("t4_c3_rvalid", 64'(imem_rvalid), 64'd1);
        chk("t4_c3_valid0", 64'(inst_valid),  64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        #1;
        chk("t4_c3_valid", 64'(inst_valid), 64'd0);
        chk("t4_c3_req",   64'(imem_req),   64'd0);
        cyc();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        #1;
        $display("T4 after redirect: valid=%b req=%b addr=%h", inst_valid, imem_req, imem_addr);
        chk("t4_c4_valid", 64'(inst_valid), 64'd0);
        chk("t4_c4_req",   64'(imem_req),   64'd1);
        chk("t4_c4_addr",  64'(imem_addr),  64'h80);
`ifdef FETCH_PERF_CNT_EN
        chk("t4_perf_x",   64'(perf_flushed), 64'd1);
        chk("t4_perf_f",   64'(perf_fetched), 64'd0);
`endif
        cyc(); cyc();
        chk("t4_c6_pc",    64'(inst_pc), 64'h80);
        chk("t4_c6_inst",  64'(inst),    64'h180);

        // Reset while a read is outstanding with one buffered entry.
        inst_ready = 1'b0;
        do_reset();
        cyc(); cyc(); cyc();
        chk("t6_c3_state", 64'(u_dut.state_q), 64'(WAIT));
        rst = 1'b1;
        #1;
        chk("t6_rst_req", 64'(imem_req), 64'd0);
        cyc();
        $display("T6 in reset: valid=%b req=%b inst=%h inst_pc=%h", inst_valid, imem_req, inst, inst_pc);
        chk("t6_valid", 64'(inst_valid), 64'd0);
        chk("t6_req",   64'(imem_req),   64'd0);
        chk("t6_inst",  64'(inst),       64'd0);
        chk("t6_pc",    64'(inst_pc),    64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_perf_f", 64'(perf_fetched), 64'd0);
        chk("t6_perf_x", 64'(perf_flushed), 64'd0);
`endif
        rst = 1'b0;
        #1;
        chk("t6_req_rel",  64'(imem_req),  64'd1);
        chk("t6_addr_rel", 64'(imem_addr), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
